// File: rtl/enc_pkg.sv
// enc_pkg: shared widths, FSM state type and one-hot helper for the
// event_encoder_8to3 block and its bench.
package enc_pkg;

    localparam int EV_W   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot vector for an event index.
    function automatic logic [EV_W-1:0] onehot_of(input logic [CODE_W-1:0] c);
        return EV_W'(1) << c;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// prio_pick8: combinational 8-input priority picker.
//   vec  - candidate event bits
//   code - index of the winning bit (0 when any = 0)
//   any  - at least one bit of vec is set
// LOW_FIRST = 1 picks the lowest set index, 0 picks the highest.
module prio_pick8
    import enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [EV_W-1:0]   vec,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    always_comb begin
        code = '0;
        any  = |vec;
        if (LOW_FIRST) begin
            // Scan downward so the last hit, the lowest index, wins.
            for (int i = EV_W - 1; i >= 0; i--) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < EV_W; i++) begin
                if (vec[i]) code = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder_8to3.sv
// event_encoder_8to3: sequential 8-to-3 encoder.
// Captures event pulses into a sticky pending register and presents them
// one at a time as index + one-hot under a valid/ready handshake.
//   clk, rst_n - clock, async active-low reset
//   en         - capture enable for req
//   req        - event pulses, bit k = event k
//   code       - index of the presented event
//   onehot     - one-hot of code, zero when valid = 0
//   valid      - an event is presented
//   ready      - consumer accepts on valid & ready
//   pend_cnt   - registered count of pending bits (includes presented bit)
//   overrun    - one-cycle pulse: captured req hit an already pending bit
module event_encoder_8to3
    import enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [EV_W-1:0]   req,
    output logic [CODE_W-1:0] code,
    output logic [EV_W-1:0]   onehot,
    output logic              valid,
    input  logic              ready,
    output logic [3:0]        pend_cnt,
    output logic              overrun
);

    state_t              state, state_nxt;
    logic [EV_W-1:0]     pending, pend_nxt;
    logic [EV_W-1:0]     cap, clr, remain;
    logic [CODE_W-1:0]   pick_code, code_nxt;
    logic [EV_W-1:0]     onehot_nxt;
    logic                pick_any;
    logic [3:0]          cnt_nxt;
    logic                accept;

    assign valid  = (state == PRESENT);
    assign accept = valid & ready;
    assign cap    = en ? req : '0;
    assign clr    = accept ? onehot : '0;
    // Candidates for the next presentation: registered pending minus the
    // bit retired this cycle. Same-cycle req is never considered.
    assign remain   = pending & ~clr;
    // Set wins over clear so a re-fired accepted event is not lost.
    assign pend_nxt = remain | cap;

    prio_pick8 #(.LOW_FIRST(LOW_FIRST)) u_pick (
        .vec  (remain),
        .code (pick_code),
        .any  (pick_any)
    );

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < EV_W; i++) begin
            cnt_nxt = cnt_nxt + 4'(pend_nxt[i]);
        end
    end

    always_comb begin
        state_nxt  = state;
        code_nxt   = code;
        onehot_nxt = onehot;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    code_nxt   = pick_code;
                    onehot_nxt = onehot_of(pick_code);
                    state_nxt  = PRESENT;
                end
            end
            PRESENT: begin
                // Presented event holds until accepted; no preemption.
                if (ready) begin
                    if (pick_any) begin
                        code_nxt   = pick_code;
                        onehot_nxt = onehot_of(pick_code);
                    end else begin
                        onehot_nxt = '0;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                onehot_nxt = '0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            code     <= '0;
            onehot   <= '0;
            pend_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pend_nxt;
            code     <= code_nxt;
            onehot   <= onehot_nxt;
            pend_cnt <= cnt_nxt;
            overrun  <= |(cap & remain);
        end
    end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb_event_encoder_8to3: directed bench. Two instances share stimulus,
// one lowest-first, one highest-first.
module tb_event_encoder_8to3;
    import enc_pkg::*;

    logic       clk, rst_n, en, ready;
    logic [7:0] req;
    logic [2:0] code_lo, code_hi;
    logic [7:0] onehot_lo, onehot_hi;
    logic       valid_lo, valid_hi, ovr_lo, ovr_hi;
    logic [3:0] cnt_lo, cnt_hi;

    int n_cmp = 0;
    int n_err = 0;

    event_encoder_8to3 #(.LOW_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .code(code_lo), .onehot(onehot_lo), .valid(valid_lo),
        .ready(ready), .pend_cnt(cnt_lo), .overrun(ovr_lo)
    );

    event_encoder_8to3 #(.LOW_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .code(code_hi), .onehot(onehot_hi), .valid(valid_hi),
        .ready(ready), .pend_cnt(cnt_hi), .overrun(ovr_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_lo [4];
    logic [2:0] exp_hi [4];

    initial begin
        exp_lo = '{3'd0, 3'd2, 3'd5, 3'd7};
        exp_hi = '{3'd7, 3'd5, 3'd2, 3'd0};
        rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0;
        #2;
        chk("rst_code",   32'(code_lo),   32'd0);
        chk("rst_onehot", 32'(onehot_lo), 32'h00);
        chk("rst_valid",  32'(valid_lo),  32'd0);
        chk("rst_cnt",    32'(cnt_lo),    32'd0);
        chk("rst_ovr",    32'(ovr_lo),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single event, latency 2
        en = 1'b1; req = 8'h04; ready = 1'b1;
        step(); req = '0;
        chk("t1_valid_e1", 32'(valid_lo), 32'd0);
        chk("t1_cnt_e1",   32'(cnt_lo),   32'd1);
        step();
        chk("t1_valid_e2", 32'(valid_lo),  32'd1);
        chk("t1_code",     32'(code_lo),   32'd2);
        chk("t1_onehot",   32'(onehot_lo), 32'h04);
        chk("t1_cnt_e2",   32'(cnt_lo),    32'd1);
        step();
        chk("t1_valid_e3",  32'(valid_lo),  32'd0);
        chk("t1_onehot_e3", 32'(onehot_lo), 32'h00);
        chk("t1_cnt_e3",    32'(cnt_lo),    32'd0);

        // Back-to-back drain of 8'hA5, both priorities
        req = 8'hA5;
        step(); req = '0;
        chk("t2_cnt_cap", 32'(cnt_lo), 32'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_valid_lo", 32'(valid_lo), 32'd1);
            chk("t2_code_lo",  32'(code_lo),  32'(exp_lo[k]));
            chk("t2_onehot_lo", 32'(onehot_lo), 32'(8'h01 << exp_lo[k]));
            chk("t2_code_hi",  32'(code_hi),  32'(exp_hi[k]));
            chk("t2_cnt",      32'(cnt_lo),   32'(4 - k));
        end
        step();
        chk("t2_valid_end", 32'(valid_lo), 32'd0);
        chk("t2_cnt_end",   32'(cnt_lo),   32'd0);

        // No preemption while stalled
        ready = 1'b0; req = 8'h08;
        step(); req = '0;
        step();
        chk("t3_valid", 32'(valid_lo), 32'd1);
        chk("t3_code",  32'(code_lo),  32'd3);
        req = 8'h01;
        step(); req = '0;
        chk("t3_ovr_pulse", 32'(ovr_lo), 32'd0);
        chk("t3_cnt",       32'(cnt_lo), 32'd2);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_hold_lo", 32'(code_lo), 32'd3);
            chk("t3_hold_hi", 32'(code_hi), 32'd3);
        end
        ready = 1'b1;
        step();
        chk("t3_next_code", 32'(code_lo),  32'd0);
        chk("t3_next_vld",  32'(valid_lo), 32'd1);
        chk("t3_ovr",       32'(ovr_lo),   32'd0);
        step();
        chk("t3_idle", 32'(valid_lo), 32'd0);
        ready = 1'b0;

        // Re-pend on accept, then overrun on a stalled hit
        req = 8'h10;
        step(); req = '0;
        step();
        chk("t4_code", 32'(code_lo), 32'd4);
        ready = 1'b1; req = 8'h10;
        step(); ready = 1'b0; req = '0;
        chk("t4_ovr_acc",  32'(ovr_lo),   32'd0);
        chk("t4_vld_acc",  32'(valid_lo), 32'd0);
        chk("t4_cnt_acc",  32'(cnt_lo),   32'd1);
        step();
        chk("t4_repend_vld",  32'(valid_lo), 32'd1);
        chk("t4_repend_code", 32'(code_lo),  32'd4);
        req = 8'h10;
        step(); req = '0;
        chk("t4_ovr_hit", 32'(ovr_lo), 32'd1);
        chk("t4_ovr_hi",  32'(ovr_hi), 32'd1);
        step();
        chk("t4_ovr_clr", 32'(ovr_lo), 32'd0);
        ready = 1'b1;
        step(); ready = 1'b0;
        chk("t4_drained", 32'(valid_lo), 32'd0);

        // All eight pending, drained with capture disabled
        req = 8'hFF;
        step(); req = '0;
        chk("t5_cnt8", 32'(cnt_lo), 32'd8);
        step();
        en = 1'b0; req = 8'hFF; ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t5_code_lo", 32'(code_lo),  32'(k));
            chk("t5_code_hi", 32'(code_hi),  32'(7 - k));
            chk("t5_cnt",     32'(cnt_lo),   32'(8 - k));
            chk("t5_valid",   32'(valid_lo), 32'd1);
            step();
        end
        chk("t5_valid_end", 32'(valid_lo), 32'd0);
        chk("t5_cnt_end",   32'(cnt_lo),   32'd0);
        step(); step();
        chk("t5_en0_valid", 32'(valid_lo), 32'd0);
        chk("t5_en0_cnt",   32'(cnt_lo),   32'd0);
        chk("t5_en0_ovr",   32'(ovr_lo),   32'd0);
        req = '0; ready = 1'b0; en = 1'b1;

        // Asynchronous reset mid-PRESENT
        req = 8'h20;
        step(); req = '0;
        step();
        chk("t6_pre_code", 32'(code_lo), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",  32'(valid_lo),  32'd0);
        chk("t6_rst_code",   32'(code_lo),   32'd0);
        chk("t6_rst_onehot", 32'(onehot_lo), 32'h00);
        chk("t6_rst_cnt",    32'(cnt_lo),    32'd0);
        chk("t6_rst_hi_vld", 32'(valid_hi),  32'd0);
        step();
        @(negedge clk) rst_n = 1'b1;
        step(); step();
        chk("t6_post_valid", 32'(valid_lo), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
